rx_sync_ctrl: RTL and testbench

Receive-side synchronization controller for the 8b/10b link. It sits after the 10b/8b decoder and its control stage. It watches decoded symbols and K28.5 commas to acquire and hold word alignment, and requests bit slips from the deserializer until alignment is found. Decoded data is forwarded downstream only while the link is in sync.

---
 rtl/rx_sync_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rx_sync_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_sync_ctrl.sv
// rtl/rx_sync_ctrl.sv - 8b/10b receive word-alignment FSM with bitslip requests and in-sync data forwarding
module rx_sync_ctrl #(
    parameter int LOCK_COMMAS  = 3,
    parameter int SLIP_TIMEOUT = 16,
    parameter int SLIP_WAIT    = 8,
    parameter int ERR_LIMIT    = 4,
    parameter int GOOD_RUN     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       dec_valid,
    input  logic [7:0] dec_data,
    input  logic       dec_kout,
    input  logic       dec_code_err,
    output logic       bitslip,
    output logic       sync_ok,
    output logic [1:0] sync_state,
    output logic [7:0] rx_data,
    output logic       rx_k,
    output logic       rx_valid
);

    localparam int COMMA_W = $clog2(LOCK_COMMAS + 1);
    localparam int NC_W    = $clog2(SLIP_TIMEOUT + 1);
    localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
    localparam int ERR_W   = $clog2(ERR_LIMIT + 1);
    localparam int GOOD_W  = $clog2(GOOD_RUN + 1);

    // Each counter's terminal test is made on the pre-increment value.
    localparam logic [COMMA_W-1:0] COMMA_TERM = COMMA_W'(LOCK_COMMAS - 1);
    localparam logic [NC_W-1:0]    NC_TERM    = NC_W'(SLIP_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_TERM  = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [ERR_W-1:0]   ERR_TERM   = ERR_W'(ERR_LIMIT - 1);
    localparam logic [GOOD_W-1:0]  GOOD_TERM  = GOOD_W'(GOOD_RUN - 1);

    typedef enum logic [1:0] {
        ST_LOS   = 2'b00,
        ST_CD    = 2'b01,
        ST_SYNC  = 2'b10,
        ST_SLIP  = 2'b11
    } state_t;

    state_t             state;
    logic [COMMA_W-1:0] comma_cnt;
    logic [NC_W-1:0]    nc_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [ERR_W-1:0]   err_cnt;
    logic [GOOD_W-1:0]  good_cnt;

    logic is_comma;
    logic is_bad;
    logic is_good;

    // A comma carrying a code error is treated as a bad symbol only.
    assign is_comma = dec_valid && dec_kout && (dec_data == 8'hBC) && !dec_code_err;
    assign is_bad   = dec_valid && dec_code_err;
    assign is_good  = dec_valid && !dec_code_err;

    assign sync_ok    = (state == ST_SYNC);
    assign sync_state = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_LOS;
            comma_cnt <= '0;
            nc_cnt    <= '0;
            wait_cnt  <= '0;
            err_cnt   <= '0;
            good_cnt  <= '0;
            bitslip   <= 1'b0;
            rx_data   <= 8'h00;
            rx_k      <= 1'b0;
            rx_valid  <= 1'b0;
        end else begin
            bitslip  <= 1'b0;
            rx_valid <= dec_valid && (state == ST_SYNC) && en;
            if (dec_valid) begin
                rx_data <= dec_data;
                rx_k    <= dec_kout;
            end

            if (!en) begin
                state     <= ST_LOS;
                comma_cnt <= '0;
                nc_cnt    <= '0;
                wait_cnt  <= '0;
                err_cnt   <= '0;
                good_cnt  <= '0;
            end else begin
                case (state)
                    ST_LOS: begin
                        if (is_comma) begin
                            nc_cnt <= '0;
                            if (LOCK_COMMAS == 1) begin
                                state     <= ST_SYNC;
                                comma_cnt <= '0;
                                err_cnt   <= '0;
                                good_cnt  <= '0;
                            end else begin
                                state     <= ST_CD;
                                comma_cnt <= COMMA_W'(1);
                            end
                        end else if (dec_valid) begin
                            if (nc_cnt == NC_TERM) begin
                                nc_cnt   <= '0;
                                wait_cnt <= '0;
                                bitslip  <= 1'b1;
                                state    <= ST_SLIP;
                            end else begin
                                nc_cnt <= nc_cnt + 1'b1;
                            end
                        end
                    end

                    ST_CD: begin
                        if (is_comma) begin
                            nc_cnt <= '0;
                            if (comma_cnt == COMMA_TERM) begin
                                state     <= ST_SYNC;
                                comma_cnt <= '0;
                                err_cnt   <= '0;
                                good_cnt  <= '0;
                            end else begin
                                comma_cnt <= comma_cnt + 1'b1;
                            end
                        end else if (is_bad) begin
                            state     <= ST_LOS;
                            comma_cnt <= '0;
                            nc_cnt    <= '0;
                        end else if (is_good) begin
                            if (nc_cnt == NC_TERM) begin
                                state     <= ST_LOS;
                                comma_cnt <= '0;
                                nc_cnt    <= '0;
                            end else begin
                                nc_cnt <= nc_cnt + 1'b1;
                            end
                        end
                    end

                    ST_SYNC: begin
                        if (is_bad) begin
                            good_cnt <= '0;
                            if (err_cnt == ERR_TERM) begin
                                state   <= ST_LOS;
                                err_cnt <= '0;
                            end else begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end else if (is_good) begin
                            // A clean run of GOOD_RUN symbols forgives one earlier error.
                            if (err_cnt != '0) begin
                                if (good_cnt == GOOD_TERM) begin
                                    err_cnt  <= err_cnt - 1'b1;
                                    good_cnt <= '0;
                                end else begin
                                    good_cnt <= good_cnt + 1'b1;
                                end
                            end else begin
                                good_cnt <= '0;
                            end
                        end
                    end

                    ST_SLIP: begin
                        if (wait_cnt == WAIT_TERM) begin
                            state     <= ST_LOS;
                            wait_cnt  <= '0;
                            comma_cnt <= '0;
                            nc_cnt    <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end

                    default: state <= ST_LOS;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// tb/tb_rx_sync_ctrl.sv - directed self-checking bench for rx_sync_ctrl
module tb_rx_sync_ctrl;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       dec_valid;
    logic [7:0] dec_data;
    logic       dec_kout;
    logic       dec_code_err;
    logic       bitslip;
    logic       sync_ok;
    logic [1:0] sync_state;
    logic [7:0] rx_data;
    logic       rx_k;
    logic       rx_valid;

    int errors = 0;
    int checks = 0;

    rx_sync_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .dec_valid    (dec_valid),
        .dec_data     (dec_data),
        .dec_kout     (dec_kout),
        .dec_code_err (dec_code_err),
        .bitslip      (bitslip),
        .sync_ok      (sync_ok),
        .sync_state   (sync_state),
        .rx_data      (rx_data),
        .rx_k         (rx_k),
        .rx_valid     (rx_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one symbol, let it be sampled, then settle 1 time unit past the edge.
    task automatic sym(input logic v, input logic [7:0] d, input logic k, input logic e);
        dec_valid    = v;
        dec_data     = d;
        dec_kout     = k;
        dec_code_err = e;
        @(posedge clk);
        #1;
    endtask

    task automatic comma();
        sym(1'b1, 8'hBC, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sym(1'b0, 8'h00, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic do_lock();
        do_reset();
        comma();
        comma();
        comma();
    endtask

    task automatic test_reset();
        en = 1'b1;
        reset_n = 1'b0;
        sym(1'b1, 8'hBC, 1'b1, 1'b0);
        checks++; if (sync_state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", sync_state); end
        checks++; if (sync_ok !== 1'b0) begin errors++; $display("FAIL reset_sync_ok got %b want 0", sync_ok); end
        checks++; if (bitslip !== 1'b0) begin errors++; $display("FAIL reset_bitslip got %b want 0", bitslip); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (rx_k !== 1'b0) begin errors++; $display("FAIL reset_rx_k got %b want 0", rx_k); end
        reset_n = 1'b1;
    endtask

    task automatic test_lock();
        comma();
        checks++; if (sync_state !== 2'b01) begin errors++; $display("FAIL lock_c1 got %b want 01", sync_state); end
        comma();
        checks++; if (sync_state !== 2'b01) begin errors++; $display("FAIL lock_c2 got %b want 01", sync_state); end
        comma();
        checks++; if (sync_state !== 2'b10) begin errors++; $display("FAIL lock_c3 got %b want 10", sync_state); end
        checks++; if (sync_ok !== 1'b1) begin errors++; $display("FAIL lock_sync_ok got %b want 1", sync_ok); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL lock_comma_fwd got %b want 0", rx_valid); end
        sym(1'b1, 8'h5A, 1'b0, 1'b0);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL lock_first_valid got %b want 1", rx_valid); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL lock_first_data got %h want 5a", rx_data); end
        checks++; if (rx_k !== 1'b0) begin errors++; $display("FAIL lock_first_k got %b want 0", rx_k); end
        sym(1'b0, 8'hFF, 1'b1, 1'b0);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL idle_hold got %h want 5a", rx_data); end
    endtask

    task automatic test_slip();
        do_reset();
        for (int i = 0; i < 15; i++) sym(1'b1, 8'h11, 1'b0, 1'b0);
        checks++; if (sync_state !== 2'b00 || bitslip !== 1'b0) begin errors++; $display("FAIL slip_pre got state=%b bitslip=%b want 00/0", sync_state, bitslip); end
        sym(1'b1, 8'h11, 1'b0, 1'b0);
        checks++; if (sync_state !== 2'b11) begin errors++; $display("FAIL slip_enter got %b want 11", sync_state); end
        checks++; if (bitslip !== 1'b1) begin errors++; $display("FAIL slip_pulse got %b want 1", bitslip); end
        for (int i = 1; i < 8; i++) begin
            comma();
            checks++; if (sync_state !== 2'b11 || bitslip !== 1'b0 || rx_valid !== 1'b0) begin
                errors++; $display("FAIL slip_wait%0d got state=%b bitslip=%b rx_valid=%b want 11/0/0", i, sync_state, bitslip, rx_valid);
            end
        end
        comma();
        checks++; if (sync_state !== 2'b00) begin errors++; $display("FAIL slip_exit got %b want 00", sync_state); end
        comma();
        checks++; if (sync_state !== 2'b01) begin errors++; $display("FAIL slip_after_comma got %b want 01", sync_state); end
    endtask

    task automatic test_bad_comma();
        do_reset();
        sym(1'b1, 8'hBC, 1'b1, 1'b1);
        checks++; if (sync_state !== 2'b00) begin errors++; $display("FAIL bad_comma got %b want 00", sync_state); end
    endtask

    task automatic test_err_drop();
        do_lock();
        sym(1'b1, 8'hE1, 1'b0, 1'b1);
        sym(1'b1, 8'h01, 1'b0, 1'b0);
        sym(1'b1, 8'h02, 1'b0, 1'b0);
        sym(1'b1, 8'hE2, 1'b0, 1'b1);
        sym(1'b1, 8'h03, 1'b0, 1'b0);
        sym(1'b1, 8'h04, 1'b0, 1'b0);
        sym(1'b1, 8'hE3, 1'b0, 1'b1);
        checks++; if (sync_ok !== 1'b1) begin errors++; $display("FAIL err3_hold got %b want 1", sync_ok); end
        sym(1'b1, 8'h05, 1'b0, 1'b0);
        sym(1'b1, 8'h06, 1'b0, 1'b0);
        sym(1'b1, 8'hE4, 1'b0, 1'b1);
        checks++; if (sync_ok !== 1'b0 || sync_state !== 2'b00) begin errors++; $display("FAIL err4_drop got sync_ok=%b state=%b want 0/00", sync_ok, sync_state); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hE4) begin errors++; $display("FAIL err4_fwd got valid=%b data=%h want 1/e4", rx_valid, rx_data); end
        checks++; if (bitslip !== 1'b0) begin errors++; $display("FAIL err4_bitslip got %b want 0", bitslip); end
    endtask

    task automatic test_forgive();
        do_lock();
        for (int i = 0; i < 3; i++) sym(1'b1, 8'hEE, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) sym(1'b1, 8'h20, 1'b0, 1'b0);
        checks++; if (sync_ok !== 1'b1) begin errors++; $display("FAIL forgive_run got %b want 1", sync_ok); end
        for (int i = 0; i < 3; i++) sym(1'b1, 8'hEE, 1'b0, 1'b1);
        checks++; if (sync_ok !== 1'b1 || sync_state !== 2'b10) begin errors++; $display("FAIL forgive_hold got sync_ok=%b state=%b want 1/10", sync_ok, sync_state); end
        sym(1'b1, 8'hEE, 1'b0, 1'b1);
        checks++; if (sync_ok !== 1'b0) begin errors++; $display("FAIL forgive_drop got %b want 0", sync_ok); end
    endtask

    task automatic test_cd_bad();
        do_reset();
        comma();
        comma();
        checks++; if (sync_state !== 2'b01) begin errors++; $display("FAIL cd_two got %b want 01", sync_state); end
        sym(1'b1, 8'h55, 1'b0, 1'b1);
        checks++; if (sync_state !== 2'b00) begin errors++; $display("FAIL cd_bad got %b want 00", sync_state); end
        comma();
        comma();
        checks++; if (sync_state !== 2'b01) begin errors++; $display("FAIL cd_relock2 got %b want 01", sync_state); end
        comma();
        checks++; if (sync_state !== 2'b10) begin errors++; $display("FAIL cd_relock3 got %b want 10", sync_state); end
    endtask

    task automatic test_en();
        do_lock();
        en = 1'b0;
        sym(1'b1, 8'h33, 1'b0, 1'b0);
        checks++; if (sync_state !== 2'b00 || sync_ok !== 1'b0) begin errors++; $display("FAIL en_drop got state=%b sync_ok=%b want 00/0", sync_state, sync_ok); end
        checks++; if (rx_valid !== 1'b0 || bitslip !== 1'b0) begin errors++; $display("FAIL en_outputs got valid=%b bitslip=%b want 0/0", rx_valid, bitslip); end
        comma();
        checks++; if (sync_state !== 2'b00) begin errors++; $display("FAIL en_hold got %b want 00", sync_state); end
        en = 1'b1;
        comma();
        comma();
        checks++; if (sync_state !== 2'b01) begin errors++; $display("FAIL en_relock2 got %b want 01", sync_state); end
        comma();
        checks++; if (sync_state !== 2'b10) begin errors++; $display("FAIL en_relock3 got %b want 10", sync_state); end
        reset_n = 1'b0;
        sym(1'b1, 8'h77, 1'b0, 1'b0);
        checks++; if (sync_state !== 2'b00 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            errors++; $display("FAIL rst_en got state=%b valid=%b data=%h want 00/0/00", sync_state, rx_valid, rx_data);
        end
        reset_n = 1'b1;
        comma();
        checks++; if (sync_state !== 2'b01) begin errors++; $display("FAIL rst_en_comma got %b want 01", sync_state); end
    endtask

    initial begin
        reset_n      = 1'b0;
        en           = 1'b1;
        dec_valid    = 1'b0;
        dec_data     = 8'h00;
        dec_kout     = 1'b0;
        dec_code_err = 1'b0;
        #2;
        test_reset();
        test_lock();
        test_slip();
        test_bad_comma();
        test_err_drop();
        test_forgive();
        test_cd_bad();
        test_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
